// File: rtl/pow2_signed_divide_sequencer.sv
// rtl/pow2_signed_divide_sequencer.sv - serial signed divide by 2^s with floor or truncate rounding
//
// One arithmetic right shift per clock replaces a barrel shifter. A sticky
// bit collects every 1 shifted out; in truncate mode a negative operand with
// a nonzero remainder gets a +1 correction so the result rounds toward zero.
// Handshake signals are pure decodes of the registered state, so there is no
// combinational path from in_valid or out_ready to any output.

module pow2_signed_divide_sequencer #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_s,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          out_inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          sticky_q, sticky_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  res_q, res_d;
  logic          inexact_q, inexact_d;

  // Corrected accumulator used in ROUND; acc <= -1 whenever the +1 applies,
  // so the increment can never wrap to a wrong sign.
  logic          round_up;
  logic [N-1:0]  acc_rounded;

  assign round_up    = mode_q & sign_q & sticky_q;
  assign acc_rounded = round_up ? (acc_q + N'(1)) : acc_q;

  // State register and datapath flops; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      sticky_q  <= 1'b0;
      sign_q    <= 1'b0;
      res_q     <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      sticky_q  <= sticky_d;
      sign_q    <= sign_d;
      res_q     <= res_d;
      inexact_q <= inexact_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    sticky_d  = sticky_q;
    sign_d    = sign_q;
    res_d     = res_q;
    inexact_d = inexact_q;

    case (state_q)
      IDLE: begin
        // Inputs are captured only here, so later changes while busy are ignored.
        if (in_valid) begin
          acc_d    = in_a;
          cnt_d    = in_s;
          mode_d   = in_mode;
          sticky_d = 1'b0;
          sign_d   = in_a[N-1];
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // Sign fill keeps going past N steps, so large s settles to 0 or -1.
        if (cnt_q != '0) begin
          sticky_d = sticky_q | acc_q[0];
          acc_d    = {acc_q[N-1], acc_q[N-1:1]};
          cnt_d    = cnt_q - SW'(1);
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        acc_d     = acc_rounded;
        res_d     = acc_rounded;
        inexact_d = sticky_q;
        state_d   = DONE;
      end

      DONE: begin
        // Result registers are untouched here, so they hold under backpressure.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_res     = res_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_pow2_signed_divide_sequencer.sv
// tb/tb_pow2_signed_divide_sequencer.sv - directed checks for pow2_signed_divide_sequencer

module tb_pow2_signed_divide_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_s;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_inexact;

  int n_cmp = 0;
  int n_err = 0;

  pow2_signed_divide_sequencer #(.N(8), .SW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_s       (in_s),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, return cycles from the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [2:0] s, input logic m,
                          input string tag);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_s     = s;
    in_mode  = m;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept_timeout"}, guard < 50, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_s     = ~s;
    in_mode  = ~m;
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_result_timeout"}, lat < 40, 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [2:0] s, input logic m,
                        input logic [7:0] er, input logic ei, input int elat,
                        input string tag);
    int lat;
    start_op(a, s, m, tag);
    check({tag, "_busy"}, in_ready, 0);
    wait_result(tag, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, out_res, er);
    check({tag, "_inexact"}, out_inexact, ei);
    release_result();
    check({tag, "_idle"}, in_ready, 1);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_s      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 8'h00);
    check("rst_out_inexact", out_inexact, 0);
    rst_n = 1'b1;

    // Floor vs truncate on -7 / 8.
    run_op(8'hF9, 3'd3, 1'b0, 8'hFF, 1'b1, 5, "m7s3_floor");
    run_op(8'hF9, 3'd3, 1'b1, 8'h00, 1'b1, 5, "m7s3_trunc");
    // Exact cases: no correction.
    run_op(8'hF8, 3'd3, 1'b1, 8'hFF, 1'b0, 5, "m8s3_trunc");
    run_op(8'h64, 3'd2, 1'b0, 8'h19, 1'b0, 4, "p100s2_floor");
    run_op(8'h64, 3'd2, 1'b1, 8'h19, 1'b0, 4, "p100s2_trunc");
    run_op(8'h9C, 3'd2, 1'b1, 8'hE7, 1'b0, 4, "m100s2_trunc");
    run_op(8'h9B, 3'd2, 1'b0, 8'hE6, 1'b1, 4, "m101s2_floor");
    run_op(8'h9B, 3'd2, 1'b1, 8'hE7, 1'b1, 4, "m101s2_trunc");
    // s = 0 and s near/over the width.
    run_op(8'h80, 3'd0, 1'b0, 8'h80, 1'b0, 2, "m128s0_floor");
    run_op(8'h80, 3'd0, 1'b1, 8'h80, 1'b0, 2, "m128s0_trunc");
    run_op(8'hFB, 3'd7, 1'b0, 8'hFF, 1'b1, 9, "m5s7_floor");
    run_op(8'hFB, 3'd7, 1'b1, 8'h00, 1'b1, 9, "m5s7_trunc");
    run_op(8'h5A, 3'd7, 1'b0, 8'h00, 1'b1, 9, "p90s7_floor");
    run_op(8'hFF, 3'd7, 1'b0, 8'hFF, 1'b1, 9, "m1s7_floor");
    run_op(8'hFF, 3'd7, 1'b1, 8'h00, 1'b1, 9, "m1s7_trunc");
    run_op(8'h00, 3'd7, 1'b1, 8'h00, 1'b0, 9, "zero_s7");
    run_op(8'h80, 3'd7, 1'b1, 8'hFF, 1'b0, 9, "m128s7_trunc");
    run_op(8'h7F, 3'd6, 1'b1, 8'h01, 1'b1, 8, "p127s6_trunc");

    // Asynchronous reset in the middle of SHIFT.
    start_op(8'h80, 3'd5, 1'b0, "rst_mid");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_res", out_res, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h80, 3'd5, 1'b0, 8'hFC, 1'b0, 7, "after_rst");

    // Backpressure: hold the result 10 cycles, then back-to-back acceptance.
    start_op(8'h64, 3'd2, 1'b1, "bp");
    wait_result("bp", lat);
    check("bp_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_res_%0d", i), out_res, 8'h19);
      check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_hold_in_ready_%0d", i), in_ready, 0);
    end
    in_valid  = 1'b1;
    in_a      = 8'hF9;
    in_s      = 3'd3;
    in_mode   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_turn_in_ready", in_ready, 1);
    check("bp_turn_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_s     = 3'd0;
    in_mode  = 1'b0;
    check("bp_next_accepted", in_ready, 0);
    wait_result("bp_next", lat);
    check("bp_next_lat", lat, 5);
    check("bp_next_res", out_res, 8'h00);
    check("bp_next_inexact", out_inexact, 1);
    release_result();
    check("bp_next_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
